// File: rtl/equalize_lut_loader.sv
`default_nettype none
// ============================================================================
//  Module   : equalize_lut_loader
//  Purpose  : Streams histogram-equalisation quotient lines from scratch memory
//             into a 256-entry LUT, eight saturated 8-bit bins per line.
//  Revision : 1.0  initial release
// ============================================================================
module equalize_lut_loader #(
    parameter logic [15:0] BASE_ADDR = 16'd128,
    parameter int          NUM_LINES = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    output logic [15:0]  sc_mem_rd_addr,
    input  logic [127:0] sc_mem_rd_data,
    input  logic         lut_ready,
    output logic         lut_wt_en,
    output logic [7:0]   lut_wt_addr,
    output logic [7:0]   lut_wt_data,
    output logic         busy,
    output logic         lut_done
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE_RD = 3'd1,
        S_RD_WAIT1 = 3'd2,
        S_RD_WAIT2 = 3'd3,
        S_CAPTURE  = 3'd4,
        S_SHIFT    = 3'd5,
        S_COMPLETE = 3'd6
    } state_t;

    localparam logic [4:0] LAST_LINE = 5'(NUM_LINES - 1);

    state_t        state_q,    state_d;
    logic [15:0]   rd_addr_q,  rd_addr_d;
    logic [4:0]    line_idx_q, line_idx_d;
    logic [2:0]    lane_q,     lane_d;
    logic [127:0]  line_buf_q, line_buf_d;
    logic          wt_en_q,    wt_en_d;
    logic [7:0]    wt_addr_q,  wt_addr_d;
    logic [7:0]    wt_data_q,  wt_data_d;
    logic          done_q,     done_d;

    logic [15:0]   w_lane_val;
    logic [7:0]    w_sat;

    assign w_lane_val = line_buf_q[{lane_q, 4'b0000} +: 16];
    assign w_sat      = (w_lane_val[15:8] == 8'd0) ? w_lane_val[7:0] : 8'hFF;

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        line_idx_d = line_idx_q;
        lane_d     = lane_q;
        line_buf_d = line_buf_q;
        wt_en_d    = 1'b0;
        wt_addr_d  = wt_addr_q;
        wt_data_d  = wt_data_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d    = S_ISSUE_RD;
                    rd_addr_d  = BASE_ADDR;
                    line_idx_d = 5'd0;
                    lane_d     = 3'd0;
                end
            end
            S_ISSUE_RD: state_d = S_RD_WAIT1;
            S_RD_WAIT1: state_d = S_RD_WAIT2;
            S_RD_WAIT2: state_d = S_CAPTURE;
            S_CAPTURE: begin
                line_buf_d = sc_mem_rd_data;
                lane_d     = 3'd0;
                state_d    = S_SHIFT;
            end
            S_SHIFT: begin
                // Backpressure simply holds lane and buffer; no write is issued.
                if (lut_ready) begin
                    wt_en_d   = 1'b1;
                    wt_addr_d = {line_idx_q, lane_q};
                    wt_data_d = w_sat;
                    lane_d    = lane_q + 3'd1;
                    if (lane_q == 3'd7) begin
                        if (line_idx_q < LAST_LINE) begin
                            rd_addr_d  = rd_addr_q + 16'd1;
                            line_idx_d = line_idx_q + 5'd1;
                            state_d    = S_ISSUE_RD;
                        end else begin
                            state_d = S_COMPLETE;
                        end
                    end
                end
            end
            S_COMPLETE: begin
                // Registered, so the pulse lands one cycle after the final write strobe.
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rd_addr_q  <= BASE_ADDR;
            line_idx_q <= 5'd0;
            lane_q     <= 3'd0;
            line_buf_q <= '0;
            wt_en_q    <= 1'b0;
            wt_addr_q  <= 8'd0;
            wt_data_q  <= 8'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            line_idx_q <= line_idx_d;
            lane_q     <= lane_d;
            line_buf_q <= line_buf_d;
            wt_en_q    <= wt_en_d;
            wt_addr_q  <= wt_addr_d;
            wt_data_q  <= wt_data_d;
            done_q     <= done_d;
        end
    end

    assign sc_mem_rd_addr = rd_addr_q;
    assign lut_wt_en      = wt_en_q;
    assign lut_wt_addr    = wt_addr_q;
    assign lut_wt_data    = wt_data_q;
    assign lut_done       = done_q;
    assign busy           = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_equalize_lut_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_equalize_lut_loader
//  Purpose  : Scoreboard bench for equalize_lut_loader with a 2-cycle memory.
//  Revision : 1.0  initial release
// ============================================================================
module tb_equalize_lut_loader;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         lut_ready;
    logic [15:0]  sc_mem_rd_addr;
    logic [127:0] sc_mem_rd_data;
    logic         lut_wt_en;
    logic [7:0]   lut_wt_addr;
    logic [7:0]   lut_wt_data;
    logic         busy;
    logic         lut_done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_wr_cyc = 0;

    logic [15:0]  exp_q[$];
    logic [127:0] mem [0:31];
    logic [127:0] rd_p1, rd_p2;

    equalize_lut_loader #(.BASE_ADDR(16'd128), .NUM_LINES(32)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .sc_mem_rd_addr(sc_mem_rd_addr), .sc_mem_rd_data(sc_mem_rd_data),
        .lut_ready(lut_ready), .lut_wt_en(lut_wt_en), .lut_wt_addr(lut_wt_addr),
        .lut_wt_data(lut_wt_data), .busy(busy), .lut_done(lut_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scratch memory with two cycles of read latency.
    always @(posedge clk) begin
        if (sc_mem_rd_addr >= 16'd128 && sc_mem_rd_addr < 16'd160)
            rd_p1 <= mem[sc_mem_rd_addr[4:0]];
        else
            rd_p1 <= '0;
        rd_p2 <= rd_p1;
    end
    assign sc_mem_rd_data = rd_p2;

    // Monitor: every write is matched against the scoreboard.
    always @(negedge clk) begin
        logic [15:0] e;
        if (lut_wt_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: got addr=%0d data=%h, required no write", lut_wt_addr, lut_wt_data);
            end else begin
                e = exp_q.pop_front();
                if ({lut_wt_addr, lut_wt_data} !== e) begin
                    errors++;
                    $display("FAIL wr_match: got addr=%0d data=%h, required addr=%0d data=%h",
                             lut_wt_addr, lut_wt_data, e[15:8], e[7:0]);
                end
            end
            if (lut_wt_addr == 8'd255) last_wr_cyc = cyc;
        end
        if (lut_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            checks++;
            if (lut_wt_en !== 1'b0) begin
                errors++;
                $display("FAIL done_overlap: got lut_wt_en=%b with lut_done, required 0", lut_wt_en);
            end
        end
    end

    task automatic load_nominal();
        for (int n = 0; n < 32; n++)
            for (int k = 0; k < 8; k++)
                mem[n][k*16 +: 16] = 16'((16 * (8 * n + k)) % 256);
    endtask

    task automatic push_pass();
        logic [15:0] x;
        logic [7:0]  d;
        for (int b = 0; b < 256; b++) begin
            x = mem[b / 8][(b % 8) * 16 +: 16];
            d = (x > 16'd255) ? 8'hFF : x[7:0];
            exp_q.push_back({8'(b), d});
        end
    endtask

    task automatic pulse_enable();
        @(negedge clk) enable = 1'b1;
        @(negedge clk) enable = 1'b0;
    endtask

    task automatic wait_write(input logic [7:0] a);
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (lut_wt_en === 1'b1 && lut_wt_addr == a) return;
        end
        checks++; errors++;
        $display("FAIL wait_write_timeout: got no write to addr %0d, required one", a);
    endtask

    task automatic wait_done(input int base);
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (done_cnt != base) return;
        end
        checks++; errors++;
        $display("FAIL wait_done_timeout: got done_cnt=%0d, required change from %0d", done_cnt, base);
    endtask

    task automatic check_queue_empty(input string tag);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_remaining: got %0d pending writes, required 0", tag, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; lut_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, lut_wt_en, lut_done, lut_wt_addr, lut_wt_data} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b en=%b done=%b addr=%0d data=%h, required all 0",
                     busy, lut_wt_en, lut_done, lut_wt_addr, lut_wt_data);
        end
        checks++;
        if (sc_mem_rd_addr !== 16'd128) begin
            errors++;
            $display("FAIL reset_rd_addr: got %0d, required 128", sc_mem_rd_addr);
        end
        enable = 1'b0; reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_nominal();
        int start, base;
        load_nominal();
        push_pass();
        base = done_cnt;
        pulse_enable();
        start = cyc;
        checks++;
        if (busy !== 1'b1 || sc_mem_rd_addr !== 16'd128) begin
            errors++;
            $display("FAIL issue_rd: got busy=%b rd_addr=%0d, required busy=1 rd_addr=128", busy, sc_mem_rd_addr);
        end
        wait_write(8'd6);
        checks++;
        if (sc_mem_rd_addr !== 16'd128) begin
            errors++;
            $display("FAIL rd_addr_hold: got %0d at bin 6, required 128", sc_mem_rd_addr);
        end
        @(negedge clk);
        checks++;
        if (sc_mem_rd_addr !== 16'd129) begin
            errors++;
            $display("FAIL rd_addr_next: got %0d after bin 7, required 129", sc_mem_rd_addr);
        end
        wait_done(base);
        checks++;
        if (done_cyc - start != 385 || done_cyc != last_wr_cyc + 1) begin
            errors++;
            $display("FAIL pass_timing: got done@%0d last_wr@%0d start@%0d, required done=start+385=last_wr+1",
                     done_cyc, last_wr_cyc, start);
        end
        check_queue_empty("nominal");
    endtask

    task automatic test_saturation();
        int base;
        mem[0][63:48] = 16'h0123;
        mem[0][79:64] = 16'h00FE;
        push_pass();
        base = done_cnt;
        pulse_enable();
        wait_write(8'd3);
        checks++;
        if (lut_wt_data !== 8'hFF) begin
            errors++;
            $display("FAIL sat_bin3: got %h, required ff", lut_wt_data);
        end
        @(negedge clk);
        checks++;
        if (lut_wt_en !== 1'b1 || lut_wt_addr !== 8'd4 || lut_wt_data !== 8'hFE) begin
            errors++;
            $display("FAIL sat_bin4: got en=%b addr=%0d data=%h, required en=1 addr=4 data=fe",
                     lut_wt_en, lut_wt_addr, lut_wt_data);
        end
        wait_done(base);
        check_queue_empty("saturation");
        load_nominal();
    endtask

    task automatic test_backpressure();
        int base;
        push_pass();
        base = done_cnt;
        pulse_enable();
        wait_write(8'd33);
        lut_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (lut_wt_en !== 1'b0) begin
                errors++;
                $display("FAIL stall_no_write: got en=%b addr=%0d in stall cycle %0d, required en=0",
                         lut_wt_en, lut_wt_addr, i);
            end
        end
        lut_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (lut_wt_en !== 1'b1 || lut_wt_addr !== 8'd34) begin
            errors++;
            $display("FAIL stall_resume: got en=%b addr=%0d, required en=1 addr=34", lut_wt_en, lut_wt_addr);
        end
        wait_done(base);
        check_queue_empty("backpressure");
    endtask

    task automatic test_reset_mid_pass();
        int base;
        push_pass();
        base = done_cnt;
        pulse_enable();
        wait_write(8'd82);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || lut_wt_en !== 1'b0 || lut_done !== 1'b0 || sc_mem_rd_addr !== 16'd128) begin
            errors++;
            $display("FAIL mid_reset: got busy=%b en=%b done=%b rd_addr=%0d, required 0 0 0 128",
                     busy, lut_wt_en, lut_done, sc_mem_rd_addr);
        end
        reset = 1'b0;
        exp_q.delete();
        repeat (20) @(negedge clk);
        checks++;
        if (done_cnt != base || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_quiet: got done_cnt=%0d busy=%b, required %0d 0", done_cnt, busy, base);
        end
        push_pass();
        pulse_enable();
        wait_write(8'd0);
        wait_done(base);
        check_queue_empty("reset_restart");
    endtask

    task automatic test_enable_while_busy();
        int base;
        push_pass();
        base = done_cnt;
        pulse_enable();
        wait_write(8'd40);
        enable = 1'b1;
        @(negedge clk) enable = 1'b0;
        wait_done(base);
        repeat (30) @(negedge clk);
        checks++;
        if (done_cnt != base + 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_enable: got done pulses=%0d busy=%b, required 1 0", done_cnt - base, busy);
        end
        check_queue_empty("busy_enable");
    endtask

    task automatic test_back_to_back();
        int base;
        push_pass();
        push_pass();
        base = done_cnt;
        @(negedge clk) enable = 1'b1;
        wait_done(base);
        @(negedge clk) enable = 1'b0;
        checks++;
        if (busy !== 1'b1 || sc_mem_rd_addr !== 16'd128) begin
            errors++;
            $display("FAIL b2b_restart: got busy=%b rd_addr=%0d, required busy=1 rd_addr=128", busy, sc_mem_rd_addr);
        end
        wait_done(base + 1);
        checks++;
        if (done_cnt != base + 2) begin
            errors++;
            $display("FAIL b2b_done: got %0d pulses, required 2", done_cnt - base);
        end
        check_queue_empty("back_to_back");
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; lut_ready = 1'b1;
        load_nominal();
        test_reset();
        test_nominal();
        test_saturation();
        test_backpressure();
        test_reset_mid_pass();
        test_enable_while_busy();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/equalize_lut_loader.md
EQUALIZE_LUT_LOADER -- requirements
Module: equalize_lut_loader

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 16'd128, meaning the scratch-memory address of the first quotient line.
REQ-002 The block SHALL have parameter NUM_LINES, default 32, meaning the number of quotient lines to read; each line holds 8 lanes, giving 256 bins.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  start request; sampled only in IDLE.
REQ-006 sc_mem_rd_addr  output  16  scratch-memory read address, registered.
REQ-007 sc_mem_rd_data  input  128  scratch read data; lane k = bits [16k+15:16k], k=0..7.
REQ-008 lut_ready  input  1  downstream LUT can accept a write this cycle.
REQ-009 lut_wt_en  output  1  one-cycle LUT write strobe, registered.
REQ-010 lut_wt_addr  output  8  bin index, registered.
REQ-011 lut_wt_data  output  8  equalized pixel value, registered.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 lut_done  output  1  one-cycle pulse after the last LUT write.

Function
REQ-014 The FSM SHALL have the states IDLE, ISSUE_RD, RD_WAIT1, RD_WAIT2, CAPTURE, SHIFT and COMPLETE.
REQ-015 IDLE SHALL move to ISSUE_RD when enable=1 and SHALL load sc_mem_rd_addr=BASE_ADDR and line_idx=0 on that transition.
REQ-016 While busy, enable SHALL be ignored, with no restart and no effect on the counters.
REQ-017 ISSUE_RD SHALL go to RD_WAIT1, then RD_WAIT2, then CAPTURE, one cycle each unconditionally; this is a 2-cycle memory latency.
REQ-018 In CAPTURE, the block SHALL register sc_mem_rd_data into a 128-bit line buffer, set lane=0, and go to SHIFT.
REQ-019 In SHIFT with lut_ready=1, the next cycle SHALL present lut_wt_en=1, lut_wt_addr={line_idx[4:0],lane[2:0]} and lut_wt_data=sat8(buffer lane); lane SHALL then increment.
REQ-020 In SHIFT with lut_ready=0, the block SHALL emit no write on the next cycle (lut_wt_en=0), and lane and the buffer SHALL hold; there is no stall limit.
REQ-021 sat8(x) SHALL be x[7:0] when x[15:8]==0, else 8'hFF.
REQ-022 On the accepted write of lane 7:
- if line_idx < NUM_LINES-1: sc_mem_rd_addr += 1, line_idx += 1, next state ISSUE_RD;
- else: next state COMPLETE.
REQ-023 COMPLETE SHALL assert lut_done=1 for exactly one cycle and return to IDLE; lut_done SHALL NOT overlap any lut_wt_en pulse.
REQ-024 lut_wt_en SHALL be 0 in every cycle not directly following an accepted SHIFT cycle.
REQ-025 Address arithmetic SHALL be 16-bit unsigned; the final address SHALL be BASE_ADDR+NUM_LINES-1, with no wrap for the defaults.
REQ-026 Latency per line SHALL be 4 cycles from ISSUE_RD to first SHIFT, plus 8 accepted SHIFT cycles.
REQ-027 With lut_ready held at 1, the block SHALL write exactly 256 bins for the defaults, each bin once, in ascending order.
REQ-028 enable=1 held through COMPLETE SHALL start a new pass only after IDLE has been entered, on the following cycle.

Reset
REQ-029 reset=1 SHALL force state=IDLE, line_idx=0, lane=0 and sc_mem_rd_addr=BASE_ADDR on the next rising edge.
REQ-030 reset=1 SHALL force lut_wt_en=0, lut_wt_addr=0, lut_wt_data=0, busy=0 and lut_done=0 on the next rising edge.
REQ-031 reset SHALL take priority over enable and over every state, including mid-line in SHIFT; no LUT write or lut_done SHALL follow a mid-pass reset.
REQ-032 After reset deasserts, a new enable SHALL restart a full pass from BASE_ADDR.

Verification
REQ-033 Nominal pass, as follows:
- Stimulus: memory line n lane k = 16*(8n+k) mod 256 in the low byte, upper byte 0; lut_ready=1; enable pulse.
- Response: 256 writes, addr 0..255 ascending, data = low byte.
- Timing: lut_done 1 cycle after the write to addr 255; total pass 32*12+2 cycles.
REQ-034 Saturation: line 0 lane 3 = 16'h0123 -> write at addr 3 has data 8'hFF; lane 4 = 16'h00FE -> write at addr 4 has data 8'hFE.
REQ-035 Backpressure: lut_ready deasserted for 5 cycles while lane=2 of line 4 is pending -> no lut_wt_en for those 5 cycles; bin 34 is written once, after lut_ready=1; no bin is skipped or duplicated.
REQ-036 Read timing: sc_mem_rd_addr=128 in ISSUE_RD; the memory model returns data 2 cycles later -> the captured line matches address 128; addr 129 is presented only after lane 7 of line 0 is accepted.
REQ-037 Reset mid-pass: reset asserted in SHIFT of line 10 -> the next cycle shows busy=0, lut_wt_en=0 and sc_mem_rd_addr=128; a following enable restarts at bin 0.
REQ-038 Enable while busy: enable pulses at line 5 -> no effect, and exactly one lut_done is produced for the pass.
